// File: rtl/or1200_branch_resolve.sv
// EX-stage branch resolution: compares the ID prediction with the real outcome,
// flushes and redirects fetch on a mispredict, trains the predictor and counts events.
module or1200_branch_resolve #(
    parameter int dw    = 32,
    parameter int CNT_W = 16,
    parameter int IDX_W = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ex_valid,
    input  logic [2:0]              ex_branch_op,
    input  logic                    ex_flag,
    input  logic                    ex_predict_taken,
    input  logic [dw-1:2]           ex_branch_addrtarget,
    input  logic [dw-1:0]           ex_pc,
    input  logic                    redirect_ready,
    input  logic                    stat_clr,
    output logic                    redirect_valid,
    output logic [dw-1:0]           redirect_adr,
    output logic                    flush,
    output logic                    stall_o,
    output logic                    upd_valid,
    output logic [IDX_W-1:0]        upd_idx,
    output logic [dw-IDX_W-3:0]     upd_tag,
    output logic                    upd_taken,
    output logic [CNT_W-1:0]        stat_branches,
    output logic [CNT_W-1:0]        stat_mispredicts
);

    localparam int TAG_W = dw - IDX_W - 2;

    localparam logic [2:0] OP_NONE = 3'd0;
    localparam logic [2:0] OP_BF   = 3'd4;
    localparam logic [2:0] OP_BNF  = 3'd5;

    typedef enum logic {IDLE = 1'b0, REDIR = 1'b1} state_t;

    state_t             state_q, state_d;
    logic               flush_q, flush_d;
    logic [dw-1:0]      adr_q, adr_d;
    logic               upd_valid_q, upd_valid_d;
    logic [IDX_W-1:0]   upd_idx_q, upd_idx_d;
    logic [TAG_W-1:0]   upd_tag_q, upd_tag_d;
    logic               upd_taken_q, upd_taken_d;
    logic [CNT_W-1:0]   br_cnt_q, br_cnt_d;
    logic [CNT_W-1:0]   mp_cnt_q, mp_cnt_d;

    logic resolve, actual_taken, mispredict, train;

    // Clear wins over a same-cycle event; otherwise stick at all-ones.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt,
                                                 input logic clr, input logic evt);
        if (clr)
            return '0;
        if (evt && (cnt != '1))
            return cnt + CNT_W'(1);
        return cnt;
    endfunction

    always_comb begin
        resolve = ex_valid && (ex_branch_op != OP_NONE) && (state_q == IDLE);
        case (ex_branch_op)
            OP_BF:   actual_taken = ex_flag;
            OP_BNF:  actual_taken = ~ex_flag;
            default: actual_taken = 1'b1;
        endcase
        mispredict = resolve && (actual_taken != ex_predict_taken);
        train      = resolve && ((ex_branch_op == OP_BF) || (ex_branch_op == OP_BNF));

        state_d     = state_q;
        flush_d     = 1'b0;
        adr_d       = adr_q;
        upd_valid_d = train;
        upd_idx_d   = upd_idx_q;
        upd_tag_d   = upd_tag_q;
        upd_taken_d = upd_taken_q;

        case (state_q)
            IDLE: begin
                if (mispredict) begin
                    state_d = REDIR;
                    flush_d = 1'b1;
                    // Not-taken resumes after the delay slot.
                    adr_d   = actual_taken ? {ex_branch_addrtarget, 2'b00}
                                           : ex_pc + dw'(8);
                end
            end
            REDIR: begin
                if (redirect_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (train) begin
            upd_idx_d   = ex_branch_addrtarget[IDX_W+1:2];
            upd_tag_d   = ex_branch_addrtarget[dw-1:IDX_W+2];
            upd_taken_d = actual_taken;
        end

        br_cnt_d = sat_inc(br_cnt_q, stat_clr, resolve);
        mp_cnt_d = sat_inc(mp_cnt_q, stat_clr, mispredict);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            flush_q     <= 1'b0;
            adr_q       <= '0;
            upd_valid_q <= 1'b0;
            upd_idx_q   <= '0;
            upd_tag_q   <= '0;
            upd_taken_q <= 1'b0;
            br_cnt_q    <= '0;
            mp_cnt_q    <= '0;
        end else begin
            state_q     <= state_d;
            flush_q     <= flush_d;
            adr_q       <= adr_d;
            upd_valid_q <= upd_valid_d;
            upd_idx_q   <= upd_idx_d;
            upd_tag_q   <= upd_tag_d;
            upd_taken_q <= upd_taken_d;
            br_cnt_q    <= br_cnt_d;
            mp_cnt_q    <= mp_cnt_d;
        end
    end

    assign redirect_valid   = (state_q == REDIR);
    assign stall_o          = (state_q == REDIR);
    assign redirect_adr     = adr_q;
    assign flush            = flush_q;
    assign upd_valid        = upd_valid_q;
    assign upd_idx          = upd_idx_q;
    assign upd_tag          = upd_tag_q;
    assign upd_taken        = upd_taken_q;
    assign stat_branches    = br_cnt_q;
    assign stat_mispredicts = mp_cnt_q;

endmodule
